pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
Datapath end of the instruction-fetch interface. It holds the program counter (PC) and instruction register (IR), and computes the next PC with a mode-selected adder. It drives the program-memory (PM) address and captures PM read data. All control inputs come from the core control unit; IR is returned to it for decode.

Parameters:
PC_WIDTH, 12, PM word-address width; PC arithmetic wraps modulo 2^PC_WIDTH.
CNT_WIDTH, 16, width of the fetch counter.

Ports:
i_clk  in  1  system clock, rising edge
i_reset_n  in  1  asynchronous active-low reset
i_reset  in  1  synchronous clear from control unit, active-high
i_mode12K  in  2  adder B-operand select
i_modeAddZA  in  2  adder A-operand select
i_modePCZ  in  1  PM address source: 0 = PC, 1 = Z word address
i_loadPC  in  1  load adder result into PC at clock edge
i_loadIR  in  1  load i_pm_data into IR at clock edge
i_loadLPM  in  1  load selected PM byte into LPM data register
i_K  in  16  immediate; only [11:0] used
i_Z  in  16  Z pointer from register file
i_pm_data  in  16  PM read data, valid one cycle after address
o_pm_addr  out  PC_WIDTH  PM word address
o_PC  out  PC_WIDTH  current PC
o_IR  out  16  instruction register
o_lpm_data  out  8  last byte fetched by LPM
o_fetch_count  out  CNT_WIDTH  count of IR loads

Behaviour:
- Asynchronous reset (i_reset_n=0): PC=0, IR=16'h0000, o_lpm_data=0, o_fetch_count=0, Z-byte-select flop=0. Outputs hold these values until the first clock edge after i_reset_n rises.
- Synchronous clear (i_reset=1 at edge): same values as asynchronous reset. Overrides every load in that cycle.
- A operand (i_modeAddZA): 00 = PC; 10 = i_Z[PC_WIDTH-1:0]; 01 and 11 = 0.
- B operand (i_mode12K): 00 = +1; 01 = +2; 10 = sign-extended i_K[11:0] (bit 11 is the sign), truncated to PC_WIDTH; 11 = 0.
- When i_modeAddZA=10, B is forced to 0 regardless of i_mode12K. IJMP therefore yields PC=Z.
- Sum = (A+B) mod 2^PC_WIDTH. Carry is discarded, and wrap is both directions (PC=0 with K=-1 gives all-ones).
- i_loadPC=1 at edge: PC <= sum. Otherwise PC holds.
- o_pm_addr is combinational:
  - i_modePCZ=0: o_pm_addr = PC.
  - i_modePCZ=1: o_pm_addr = i_Z[PC_WIDTH:1].
- PM is synchronous with one-cycle read latency. i_pm_data in cycle n+1 reflects the address presented in cycle n.
- Fetch sequence:
  - Cycle F1: addr=PC, loadPC with modes 00/00, so PC becomes PC+1.
  - Cycle F2: i_pm_data holds the old-PC word; loadIR latches it.
- i_loadIR=1 at edge: IR <= i_pm_data and o_fetch_count increments, wrapping at 2^CNT_WIDTH to 0.
- LPM:
  - In any cycle with i_modePCZ=1, a flop latches i_Z[0] at the edge.
  - i_loadLPM=1 at the next edge: o_lpm_data <= flop ? i_pm_data[15:8] : i_pm_data[7:0].
- Simultaneous events:
  - i_loadPC and i_loadIR together: both take effect. IR gets i_pm_data; the adder uses the pre-edge PC.
  - i_loadIR and i_loadLPM together: both take effect from the same i_pm_data.
- Undefined (X) control inputs are not sanitised. The control unit guarantees defined values whenever the corresponding load is asserted.
- No combinational path from i_pm_data to any output.

Test Plan:
1. Reset: assert i_reset_n=0 mid-fetch with PC=0x123 -> PC=0, IR=0, o_fetch_count=0 immediately, without waiting for a clock edge. Release, then pulse i_reset=1 together with i_loadPC=1 -> PC stays 0.
2. Sequential fetch: PM[0..3]=0x1111,0x2222,0x3333,0x4444; run three F1/F2 pairs -> IR=0x1111, 0x2222, 0x3333 in turn; PC=3; o_fetch_count=3; o_pm_addr equals PC during each F1.
3. RJMP with wrap:
   - PC=0x005, i_K=0x0FFA (-6), modes 10/00, loadPC -> PC=0xFFF.
   - Then from PC=0xFFF, mode12K=00 -> PC=0x000.
4. IJMP: i_Z=0xABCD, modeAddZA=10, mode12K=00, loadPC -> PC=0xBCD; B operand forced to 0.
5. LPM byte select:
   - i_Z=0x0021, modePCZ=1 -> o_pm_addr=0x010.
   - PM[0x010]=0xBEEF, then loadLPM -> o_lpm_data=0xBE.
   - Repeat with i_Z=0x0020 -> o_lpm_data=0xEF.
6. Simultaneous loads: PC=7, i_pm_data=0x9409, loadPC(00/00) and loadIR on the same edge -> PC=8, IR=0x9409. Counter at all-ones plus one loadIR -> 0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// pc_fetch_unit
//
// Datapath end of the instruction-fetch interface. Holds the program counter
// (PC) and the instruction register (IR). It computes the next PC through a
// mode-selected adder, drives the program-memory word address, and captures
// PM read data into IR or into the LPM byte register.
//
// Ports
//   i_clk          system clock, rising edge
//   i_reset_n      asynchronous active-low reset
//   i_reset        synchronous clear, active-high; overrides every load
//   i_mode12K      adder B select: 00 +1, 01 +2, 10 sext(K[11:0]), 11 zero
//   i_modeAddZA    adder A select: 00 PC, 10 Z, 01/11 zero (10 forces B = 0)
//   i_modePCZ      PM address source: 0 = PC, 1 = Z word address (Z >> 1)
//   i_loadPC       PC <= adder sum at the edge
//   i_loadIR       IR <= i_pm_data and the fetch counter increments
//   i_loadLPM      LPM data <= byte of i_pm_data picked by the latched Z[0]
//   i_K            immediate; only [11:0] is used
//   i_Z            Z pointer from the register file
//   i_pm_data      PM read data, one cycle after the address
//   o_pm_addr      PM word address (combinational from PC / Z)
//   o_PC           current PC
//   o_IR           instruction register
//   o_lpm_data     last byte fetched by LPM
//   o_fetch_count  number of IR loads, wraps to zero
// ----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter int unsigned PC_WIDTH  = 12,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_reset,
    input  logic [1:0]           i_mode12K,
    input  logic [1:0]           i_modeAddZA,
    input  logic                 i_modePCZ,
    input  logic                 i_loadPC,
    input  logic                 i_loadIR,
    input  logic                 i_loadLPM,
    input  logic [15:0]          i_K,
    input  logic [15:0]          i_Z,
    input  logic [15:0]          i_pm_data,
    output logic [PC_WIDTH-1:0]  o_pm_addr,
    output logic [PC_WIDTH-1:0]  o_PC,
    output logic [15:0]          o_IR,
    output logic [7:0]           o_lpm_data,
    output logic [CNT_WIDTH-1:0] o_fetch_count
);

    logic [PC_WIDTH-1:0]  pc_q;
    logic [15:0]          ir_q;
    logic [7:0]           lpm_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 zsel_q;

    logic [PC_WIDTH-1:0]  add_a;
    logic [PC_WIDTH-1:0]  add_b;
    logic [PC_WIDTH-1:0]  add_sum;
    logic [31:0]          k_sext;

    // 12-bit immediate sign-extended wide, then cut down to the PC width.
    assign k_sext = {{20{i_K[11]}}, i_K[11:0]};

    always_comb begin
        add_a = '0;
        case (i_modeAddZA)
            2'b00:   add_a = pc_q;
            2'b10:   add_a = i_Z[PC_WIDTH-1:0];
            default: add_a = '0;
        endcase
    end

    always_comb begin
        add_b = '0;
        if (i_modeAddZA != 2'b10) begin
            case (i_mode12K)
                2'b00:   add_b = PC_WIDTH'(1);
                2'b01:   add_b = PC_WIDTH'(2);
                2'b10:   add_b = k_sext[PC_WIDTH-1:0];
                default: add_b = '0;
            endcase
        end
    end

    // Carry out is dropped: PC arithmetic wraps in both directions.
    assign add_sum = add_a + add_b;

    assign o_pm_addr = i_modePCZ ? i_Z[PC_WIDTH:1] : pc_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pc_q   <= '0;
            ir_q   <= '0;
            lpm_q  <= '0;
            cnt_q  <= '0;
            zsel_q <= 1'b0;
        end else if (i_reset) begin
            pc_q   <= '0;
            ir_q   <= '0;
            lpm_q  <= '0;
            cnt_q  <= '0;
            zsel_q <= 1'b0;
        end else begin
            if (i_loadPC) begin
                pc_q <= add_sum;
            end
            if (i_loadIR) begin
                ir_q  <= i_pm_data;
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
            // Byte select is taken from the cycle the Z address went out,
            // since the data arrives one cycle later.
            if (i_modePCZ) begin
                zsel_q <= i_Z[0];
            end
            if (i_loadLPM) begin
                lpm_q <= zsel_q ? i_pm_data[15:8] : i_pm_data[7:0];
            end
        end
    end

    assign o_PC          = pc_q;
    assign o_IR          = ir_q;
    assign o_lpm_data    = lpm_q;
    assign o_fetch_count = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Directed bench for pc_fetch_unit with a one-cycle-latency PM model. The
// fetch counter is narrowed to 8 bits so its wrap can be reached quickly.
// ----------------------------------------------------------------------------
module tb_pc_fetch_unit;

    localparam int unsigned PW = 12;
    localparam int unsigned CW = 8;

    logic          i_clk;
    logic          i_reset_n;
    logic          i_reset;
    logic [1:0]    i_mode12K;
    logic [1:0]    i_modeAddZA;
    logic          i_modePCZ;
    logic          i_loadPC;
    logic          i_loadIR;
    logic          i_loadLPM;
    logic [15:0]   i_K;
    logic [15:0]   i_Z;
    logic [15:0]   i_pm_data;
    logic [PW-1:0] o_pm_addr;
    logic [PW-1:0] o_PC;
    logic [15:0]   o_IR;
    logic [7:0]    o_lpm_data;
    logic [CW-1:0] o_fetch_count;

    logic [15:0]   pm [0:4095];

    int vectors;
    int miscompares;

    pc_fetch_unit #(.PC_WIDTH(PW), .CNT_WIDTH(CW)) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_reset       (i_reset),
        .i_mode12K     (i_mode12K),
        .i_modeAddZA   (i_modeAddZA),
        .i_modePCZ     (i_modePCZ),
        .i_loadPC      (i_loadPC),
        .i_loadIR      (i_loadIR),
        .i_loadLPM     (i_loadLPM),
        .i_K           (i_K),
        .i_Z           (i_Z),
        .i_pm_data     (i_pm_data),
        .o_pm_addr     (o_pm_addr),
        .o_PC          (o_PC),
        .o_IR          (o_IR),
        .o_lpm_data    (o_lpm_data),
        .o_fetch_count (o_fetch_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Synchronous PM: data for the address seen at an edge appears after it.
    always @(posedge i_clk) i_pm_data <= pm[o_pm_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        i_reset     = 1'b0;
        i_mode12K   = 2'b00;
        i_modeAddZA = 2'b00;
        i_modePCZ   = 1'b0;
        i_loadPC    = 1'b0;
        i_loadIR    = 1'b0;
        i_loadLPM   = 1'b0;
        i_K         = 16'h0000;
        i_Z         = 16'h0000;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic load_pc(input logic [1:0] za, input logic [1:0] k12,
                           input logic [15:0] k, input logic [15:0] z);
        idle();
        i_modeAddZA = za;
        i_mode12K   = k12;
        i_K         = k;
        i_Z         = z;
        i_loadPC    = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 4096; i++) pm[i] = 16'h0000;
        pm[0]     = 16'h1111;
        pm[1]     = 16'h2222;
        pm[2]     = 16'h3333;
        pm[3]     = 16'h4444;
        pm[7]     = 16'h9409;
        pm[8]     = 16'h5A3C;
        pm[12'h010] = 16'hBEEF;
        i_pm_data = 16'h0000;
        idle();

        // Power-on reset
        i_reset_n = 1'b0;
        #1;
        check("por_pc",  32'(o_PC), 32'h0);
        check("por_ir",  32'(o_IR), 32'h0);
        check("por_lpm", 32'(o_lpm_data), 32'h0);
        check("por_cnt", 32'(o_fetch_count), 32'h0);
        tick();
        tick();
        i_reset_n = 1'b1;

        // 1. Async reset mid-fetch, then sync clear overriding loads
        tick();                                   // PM model now returns pm[0]
        i_mode12K = 2'b10;
        i_K       = 16'h0123;
        i_loadPC  = 1'b1;
        i_loadIR  = 1'b1;
        tick();
        check("pre_rst_pc",  32'(o_PC), 32'h123);
        check("pre_rst_ir",  32'(o_IR), 32'h1111);
        check("pre_rst_cnt", 32'(o_fetch_count), 32'h1);
        i_loadPC = 1'b1;
        i_mode12K = 2'b00;
        #3;
        i_reset_n = 1'b0;
        #1;
        check("arst_pc",  32'(o_PC), 32'h0);
        check("arst_ir",  32'(o_IR), 32'h0);
        check("arst_cnt", 32'(o_fetch_count), 32'h0);
        tick();
        check("arst_hold_pc", 32'(o_PC), 32'h0);
        i_reset_n = 1'b1;
        i_reset   = 1'b1;
        i_loadPC  = 1'b1;
        i_loadIR  = 1'b1;
        tick();
        check("sclr_pc",  32'(o_PC), 32'h0);
        check("sclr_ir",  32'(o_IR), 32'h0);
        check("sclr_cnt", 32'(o_fetch_count), 32'h0);
        idle();

        // 2. Sequential fetch
        for (int n = 0; n < 3; n++) begin
            idle();
            i_loadPC = 1'b1;
            #1;
            check($sformatf("f1_addr%0d", n), 32'(o_pm_addr), 32'(n));
            tick();
            idle();
            i_loadIR = 1'b1;
            tick();
            check($sformatf("f2_ir%0d", n), 32'(o_IR), 32'h1111 * (n + 1));
        end
        idle();
        check("seq_pc",  32'(o_PC), 32'h3);
        check("seq_cnt", 32'(o_fetch_count), 32'h3);

        // 3. Adder modes and wrap
        load_pc(2'b10, 2'b01, 16'h0000, 16'h0005);
        check("ijmp5_forced_b", 32'(o_PC), 32'h005);
        load_pc(2'b00, 2'b10, 16'h0FFA, 16'h0000);
        check("rjmp_neg_wrap", 32'(o_PC), 32'hFFF);
        load_pc(2'b00, 2'b00, 16'h0000, 16'h0000);
        check("inc_wrap", 32'(o_PC), 32'h000);
        load_pc(2'b00, 2'b01, 16'h0000, 16'h0000);
        check("plus2", 32'(o_PC), 32'h002);
        load_pc(2'b01, 2'b00, 16'h0000, 16'h0000);
        check("a01_zero", 32'(o_PC), 32'h001);
        load_pc(2'b11, 2'b01, 16'h0000, 16'h0000);
        check("a11_zero", 32'(o_PC), 32'h002);
        i_mode12K = 2'b01;
        tick();
        check("no_load_hold", 32'(o_PC), 32'h002);
        load_pc(2'b01, 2'b10, 16'h07FF, 16'h0000);
        check("k_pos_max", 32'(o_PC), 32'h7FF);
        load_pc(2'b00, 2'b10, 16'hF005, 16'h0000);
        check("k_upper_ignored", 32'(o_PC), 32'h804);
        load_pc(2'b00, 2'b11, 16'h0000, 16'h0000);
        check("b11_zero", 32'(o_PC), 32'h804);

        // 4. IJMP
        load_pc(2'b10, 2'b01, 16'h0000, 16'hABCD);
        check("ijmp_pc", 32'(o_PC), 32'hBCD);
        #1;
        check("ijmp_addr_pc", 32'(o_pm_addr), 32'hBCD);

        // 5. LPM byte select (low byte, then high byte with a same-edge IR load)
        i_Z       = 16'h0020;
        i_modePCZ = 1'b1;
        #1;
        check("lpm_addr_even", 32'(o_pm_addr), 32'h010);
        tick();
        idle();
        i_Z       = 16'h0001;
        i_loadLPM = 1'b1;
        tick();
        check("lpm_low", 32'(o_lpm_data), 32'hEF);
        idle();
        i_Z       = 16'h0021;
        i_modePCZ = 1'b1;
        #1;
        check("lpm_addr_odd", 32'(o_pm_addr), 32'h010);
        tick();
        idle();
        i_loadLPM = 1'b1;
        i_loadIR  = 1'b1;
        tick();
        check("lpm_high", 32'(o_lpm_data), 32'hBE);
        check("lpm_ir_same_edge", 32'(o_IR), 32'hBEEF);
        idle();

        // 6. Simultaneous PC and IR loads
        load_pc(2'b10, 2'b00, 16'h0000, 16'h0007);
        check("set_pc7", 32'(o_PC), 32'h007);
        tick();
        i_loadPC = 1'b1;
        i_loadIR = 1'b1;
        tick();
        check("sim_pc", 32'(o_PC), 32'h008);
        check("sim_ir", 32'(o_IR), 32'h9409);
        idle();

        // Sync clear also clears LPM data and the byte-select flop
        i_reset   = 1'b1;
        i_loadLPM = 1'b1;
        tick();
        idle();
        check("sclr_lpm", 32'(o_lpm_data), 32'h00);
        check("sclr_cnt2", 32'(o_fetch_count), 32'h0);
        i_loadLPM = 1'b1;
        tick();
        check("sclr_zsel_low", 32'(o_lpm_data), 32'h3C);
        idle();

        // Fetch counter wrap
        i_loadIR = 1'b1;
        for (int n = 0; n < 255; n++) tick();
        check("cnt_all_ones", 32'(o_fetch_count), 32'hFF);
        tick();
        check("cnt_wrap", 32'(o_fetch_count), 32'h00);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
